// File: rtl/gmsk_pkg.sv
// Shared types and constants for the GMSK burst sequencer.
// Holds the burst state enum, the default burst-shape constants and the
// helper that computes the clocks-per-symbol period.
package gmsk_pkg;

    // Burst framing states, in the order a burst walks through them.
    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        PAYLOAD,
        TAIL,
        GUARD
    } state_t;

    localparam int DEF_CLOCKS_PER_SAMPLE  = 4;
    localparam int DEF_SAMPLES_PER_SYMBOL = 8;
    localparam int DEF_TAIL_BITS          = 3;
    localparam int DEF_PAYLOAD_BITS       = 142;
    localparam int DEF_GUARD_BITS         = 8;

    // Clocks in one symbol period.
    function automatic int symbol_period(input int clocks_per_sample,
                                         input int samples_per_symbol);
        return clocks_per_sample * samples_per_symbol;
    endfunction

endpackage

// File: rtl/gmsk_burst_sequencer_if.sv
// Upstream payload-bit handshake between the burst assembler (master)
// and the burst sequencer (slave).
interface gmsk_burst_sequencer_if;

    logic bit_valid;
    logic bit_in;
    logic bit_ready;

    modport master (
        output bit_valid,
        output bit_in,
        input  bit_ready
    );

    modport slave (
        input  bit_valid,
        input  bit_in,
        output bit_ready
    );

endinterface

// File: rtl/gmsk_strobe_gen.sv
// Symbol/sample strobe generator for the GMSK modulator.
// Counts the clock offset within a symbol while run is high and decodes
// the symbol strobe (offset 0), the sample strobes (offsets 1 + k*CPS)
// and the last clock of the symbol (offset P-1).
module gmsk_strobe_gen
    import gmsk_pkg::*;
#(
    parameter int CLOCKS_PER_SAMPLE  = DEF_CLOCKS_PER_SAMPLE,
    parameter int SAMPLES_PER_SYMBOL = DEF_SAMPLES_PER_SYMBOL
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic symbol_strobe,
    output logic sample_strobe,
    output logic last_clock
);

    localparam int P     = symbol_period(CLOCKS_PER_SAMPLE, SAMPLES_PER_SYMBOL);
    localparam int OFF_W = $clog2(P);
    localparam int PH_W  = $clog2(CLOCKS_PER_SAMPLE);

    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(P - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLOCKS_PER_SAMPLE - 1);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);

    logic [OFF_W-1:0] offset_reg;
    logic [PH_W-1:0]  phase_reg;

    // Offset and sample-phase counters; both held at zero while not running
    // so the first running cycle is always offset 0. P is a multiple of CPS,
    // so the phase wraps together with the offset.
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            offset_reg <= '0;
            phase_reg  <= '0;
        end else begin
            offset_reg <= (offset_reg == OFF_LAST) ? '0 : offset_reg + 1'b1;
            phase_reg  <= (phase_reg == PH_LAST) ? '0 : phase_reg + 1'b1;
        end
    end

    // Samples sit one clock after each phase-0 point, so a sample can never
    // land on offset 0 where the modulator resets its ROM index.
    assign symbol_strobe = run && (offset_reg == '0);
    assign sample_strobe = run && (phase_reg == PH_ONE);
    assign last_clock    = run && (offset_reg == OFF_LAST);

endmodule

// File: rtl/gmsk_burst_sequencer.sv
// Burst-level controller for the GMSK modulator.
// Frames each burst as head tail, payload, trailing tail and guard, pulls
// one payload bit per payload symbol from upstream, and drives the
// modulator strobes and input bit.
// Optional build macro: GMSK_DIFF_ENCODE_EN enables differential encoding
// of tx_bit (d_i = b_i xor b_{i-1}, reference bit 1 before symbol 0).
module gmsk_burst_sequencer
    import gmsk_pkg::*;
#(
    parameter int CLOCKS_PER_SAMPLE  = DEF_CLOCKS_PER_SAMPLE,
    parameter int SAMPLES_PER_SYMBOL = DEF_SAMPLES_PER_SYMBOL,
    parameter int TAIL_BITS          = DEF_TAIL_BITS,
    parameter int PAYLOAD_BITS       = DEF_PAYLOAD_BITS,
    parameter int GUARD_BITS         = DEF_GUARD_BITS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    burst_start,
    gmsk_burst_sequencer_if.slave   up,
    output logic                    symbol_strobe,
    output logic                    sample_strobe,
    output logic                    tx_bit,
    output logic                    busy,
    output logic                    burst_done,
    output logic                    underrun
);

    localparam int N     = 2 * TAIL_BITS + PAYLOAD_BITS + GUARD_BITS;
    localparam int SYM_W = $clog2(N + 1);

    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(N - 1);

    // Framing state of overall symbol index idx; zero-length sections fall
    // through to the next one, and indices past the burst map to IDLE.
    function automatic state_t state_of(input int idx);
        if (idx < TAIL_BITS)
            return HEAD;
        else if (idx < TAIL_BITS + PAYLOAD_BITS)
            return PAYLOAD;
        else if (idx < 2 * TAIL_BITS + PAYLOAD_BITS)
            return TAIL;
        else if (idx < N)
            return GUARD;
        else
            return IDLE;
    endfunction

    state_t           state_reg;
    logic [SYM_W-1:0] sym_reg;
    logic             busy_reg;
    logic             tx_reg;
    logic             underrun_reg;

    logic             last_clock;
    logic             accept;
    logic             advance;
    logic             finish;
    logic [SYM_W-1:0] sym_inc;
    logic             ready;
    logic             miss;
    logic             sel_bit;
    logic             enc_bit;

    gmsk_strobe_gen #(
        .CLOCKS_PER_SAMPLE  (CLOCKS_PER_SAMPLE),
        .SAMPLES_PER_SYMBOL (SAMPLES_PER_SYMBOL)
    ) u_strobe_gen (
        .clock         (clock),
        .reset         (reset),
        .run           (busy_reg),
        .symbol_strobe (symbol_strobe),
        .sample_strobe (sample_strobe),
        .last_clock    (last_clock)
    );

    assign accept  = (state_reg == IDLE) && burst_start && !reset;
    assign advance = busy_reg && last_clock;
    assign finish  = advance && (sym_reg == SYM_LAST);
    assign sym_inc = sym_reg + 1'b1;

    // One ready pulse per payload symbol, in the last clock before it; a
    // payload symbol 0 takes its bit in the acceptance cycle instead.
    always_comb begin
        ready = 1'b0;
        if (accept && (state_of(0) == PAYLOAD))
            ready = 1'b1;
        else if (advance && !finish && (state_of(int'(sym_inc)) == PAYLOAD))
            ready = 1'b1;
    end

    assign up.bit_ready = ready;
    assign miss         = ready && !up.bit_valid;
    // Bit for the symbol about to start: upstream bit on a transfer, 0 on a
    // missing payload bit and for every framing symbol.
    assign sel_bit      = ready && up.bit_valid && up.bit_in;

`ifdef GMSK_DIFF_ENCODE_EN
    logic prev_reg;

    // Previous selected bit for the differential encoder.
    always_ff @(posedge clock) begin
        if (reset)
            prev_reg <= 1'b1;
        else if (accept || advance)
            prev_reg <= sel_bit;
    end

    // The reference bit ahead of symbol 0 is 1, whatever the last burst left.
    assign enc_bit = sel_bit ^ (accept ? 1'b1 : prev_reg);
`else
    assign enc_bit = sel_bit;
`endif

    // Burst FSM: symbol counter, busy, registered tx bit and sticky underrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            sym_reg      <= '0;
            busy_reg     <= 1'b0;
            tx_reg       <= 1'b0;
            underrun_reg <= 1'b0;
        end else if (accept) begin
            state_reg    <= state_of(0);
            sym_reg      <= '0;
            busy_reg     <= 1'b1;
            tx_reg       <= enc_bit;
            underrun_reg <= miss;
        end else if (finish) begin
            state_reg    <= IDLE;
            sym_reg      <= '0;
            busy_reg     <= 1'b0;
            tx_reg       <= 1'b0;
        end else if (advance) begin
            state_reg    <= state_of(int'(sym_inc));
            sym_reg      <= sym_inc;
            tx_reg       <= enc_bit;
            if (miss)
                underrun_reg <= 1'b1;
        end
    end

    assign tx_bit     = tx_reg;
    assign busy       = busy_reg;
    assign burst_done = finish;
    assign underrun   = underrun_reg;

endmodule
